// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver
// controllers: default bit timing, data width and the transmit state set.
package uart_pkg;

    // 100 MHz system clock / 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    // 8N1 framing: data payload width
    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_transmitter_controller_if.sv
// Byte-source handshake between a first-word-fall-through FIFO (master)
// and the UART transmitter (slave). din is valid whenever empty is low;
// the source pops its head entry on a rising edge where re is high.
interface uart_transmitter_controller_if;

    logic [uart_pkg::DATA_BITS-1:0] din;
    logic                           empty;
    logic                           re;

    modport master (
        output din,
        output empty,
        input  re
    );

    modport slave (
        input  din,
        input  empty,
        output re
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; tick marks the
// last cycle of every bit period. clear holds the count at zero so the
// first bit after leaving idle gets a full period.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;

    // Free-running bit timer, restarted by clear and wrapped at the bit boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clear || (cnt_reg == CNT_LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign tick = ~clear & (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_transmitter_controller.sv
// 8N1 UART transmitter. Pulls bytes from a FWFT byte source and shifts
// them out LSB first behind a start bit and ahead of a stop bit. The TX
// line is driven straight from a flop so it never glitches; a new byte
// is accepted only from IDLE, which leaves exactly one idle cycle
// between back-to-back frames.
module uart_transmitter_controller
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_transmitter_controller_if.slave  src,
    output logic                          dout
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    tx_state_e              state_reg, state_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [IDX_W-1:0]       bit_idx_reg, bit_idx_next;
    logic                   dout_reg, dout_next;
    logic                   re_next;
    logic                   baud_clear;
    logic                   baud_tick;

    // The bit timer is parked at zero while idle so START gets a full period
    assign baud_clear = (state_reg == IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (baud_tick)
    );

    // State, shift register, bit index and line register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            dout_reg    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            dout_reg    <= dout_next;
        end
    end

    // Next-state logic; dout_next is the line level for the coming cycle
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        dout_next    = dout_reg;
        re_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                dout_next = 1'b1;
                // Held off while reset is asserted so the source never pops a byte we drop
                if (!src.empty && !rst) begin
                    re_next    = 1'b1;
                    shift_next = src.din;
                    state_next = START;
                    dout_next  = 1'b0;
                end
            end

            START: begin
                if (baud_tick) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    dout_next    = shift_reg[0];
                end
            end

            DATA: begin
                if (baud_tick) begin
                    shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
                    if (bit_idx_reg == IDX_LAST) begin
                        state_next = STOP;
                        dout_next  = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + IDX_W'(1);
                        dout_next    = shift_reg[1];
                    end
                end
            end

            STOP: begin
                dout_next = 1'b1;
                if (baud_tick) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                dout_next  = 1'b1;
            end
        endcase
    end

    assign src.re = re_next;
    assign dout   = dout_reg;

endmodule

// File: tb/tb_uart_transmitter_controller.sv
// Randomised and directed checks of the UART transmitter against a
// frame-time reference model plus an independent mid-bit line decoder.
module tb_uart_transmitter_controller;
    import uart_pkg::*;

    localparam int N     = 4;          // clocks per bit for this bench
    localparam int FRAME = 10 * N;     // start + 8 data + stop

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dout;

    uart_transmitter_controller_if bus();

    uart_transmitter_controller #(
        .CLKS_PER_BIT (N)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .src  (bus),
        .dout (dout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: position inside the current frame (-1 = idle)
    int          frame_t    = -1;
    logic [7:0]  frame_byte = 8'h00;
    logic        exp_re;
    logic        exp_dout;
    logic [7:0]  exp_q[$];

    // Line decoder state
    int          rx_t = -1;
    logic [7:0]  rx_byte = 8'h00;

    // Cycle numbers at which the DUT raised re
    int          dut_re_cyc[$];

    function automatic logic model_dout(int t, logic [7:0] b);
        int bit_no;
        if (t < 0) return 1'b1;
        bit_no = t / N;
        if (bit_no == 0) return 1'b0;
        if (bit_no >= 9) return 1'b1;
        return b[bit_no-1];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge
    task automatic cycle();
        int k;
        @(negedge clk);
        exp_re   = (frame_t < 0) && !bus.empty;
        exp_dout = model_dout(frame_t, frame_byte);
        check("re", bus.re, exp_re);
        check("dout", dout, exp_dout);
        if (bus.re === 1'b1) dut_re_cyc.push_back(cyc);

        if (rx_t < 0) begin
            if (dout === 1'b0) rx_t = 0;
        end else begin
            rx_t++;
        end
        if (rx_t >= 0 && (rx_t % N) == N / 2) begin
            k = rx_t / N;
            if (k == 0) begin
                check("rx_start", dout, 1'b0);
            end else if (k <= 8) begin
                rx_byte[k-1] = dout;
            end else begin
                check("rx_stop", dout, 1'b1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL rx_unexpected: observed=%0h expected=none", rx_byte);
                end else begin
                    check("rx_byte", rx_byte, exp_q.pop_front());
                end
                rx_t = -1;
            end
        end

        @(posedge clk);
        if (exp_re) begin
            frame_t    = 0;
            frame_byte = bus.din;
            exp_q.push_back(bus.din);
        end else if (frame_t >= 0) begin
            frame_t++;
            if (frame_t == FRAME) frame_t = -1;
        end
        #1;
        cyc++;
    endtask

    initial begin
        int n0;
        int guard;

        // Reset held with a byte on offer: line high, no pop
        bus.din   = 8'h36;
        bus.empty = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_dout", dout, 1'b1);
            check("rst_re", bus.re, 1'b0);
        end
        @(posedge clk);
        #1;
        bus.empty = 1'b1;
        rst = 1'b0;
        repeat (2) cycle();

        // Single byte 0x36, offered for one cycle
        bus.din = 8'h36; bus.empty = 1'b0;
        cycle();
        bus.empty = 1'b1; bus.din = 8'hC3;
        repeat (FRAME + 3) cycle();

        // Busy hold-off: byte offered mid-frame must wait for IDLE
        bus.din = 8'hA5; bus.empty = 1'b0;
        cycle();
        bus.empty = 1'b1;
        repeat (15) cycle();
        bus.din = 8'h2B; bus.empty = 1'b0;
        repeat (5) cycle();
        guard = 0;
        while (frame_t >= 0 && guard < 2 * FRAME) begin
            cycle();
            guard++;
        end
        cycle();                      // first IDLE cycle: re expected here
        bus.empty = 1'b1;
        repeat (FRAME + 2) cycle();

        // Back-to-back 0x41, 0x42
        n0 = dut_re_cyc.size();
        bus.din = 8'h41; bus.empty = 1'b0;
        guard = 0;
        while (dut_re_cyc.size() < n0 + 1 && guard < 3 * FRAME) begin
            cycle();
            guard++;
        end
        bus.din = 8'h42;
        guard = 0;
        while (dut_re_cyc.size() < n0 + 2 && guard < 3 * FRAME) begin
            cycle();
            guard++;
        end
        bus.empty = 1'b1;
        check("b2b_pulses", dut_re_cyc.size(), n0 + 2);
        if (dut_re_cyc.size() >= n0 + 2)
            check("b2b_gap", dut_re_cyc[n0+1] - dut_re_cyc[n0], FRAME + 1);
        repeat (FRAME + 2) cycle();

        // All-ones byte
        bus.din = 8'hFF; bus.empty = 1'b0;
        cycle();
        bus.empty = 1'b1;
        repeat (FRAME + 2) cycle();

        // Random offers; din churns while busy to show only the re edge samples it
        repeat (40 * FRAME) begin
            bus.empty = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 1) == 1) bus.din = 8'($urandom);
            cycle();
        end
        bus.empty = 1'b1;
        repeat (FRAME + 2) cycle();

        // Reset in the middle of DATA aborts the frame
        bus.din = 8'h5A; bus.empty = 1'b0;
        cycle();
        bus.empty = 1'b1;
        repeat (3 * N + 1) cycle();
        bus.empty = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_dout", dout, 1'b1);
        @(negedge clk);
        check("abort_re", bus.re, 1'b0);
        check("abort_dout_held", dout, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        frame_t = -1;
        rx_t    = -1;
        exp_q.delete();
        cyc++;

        // First cycle after release must be IDLE: a new byte is taken at once
        bus.din = 8'h99; bus.empty = 1'b0;
        cycle();
        bus.empty = 1'b1;
        repeat (FRAME + 3) cycle();

        check("rx_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
